// File: rtl/lcd_refresh_scheduler_pkg.sv
// Shared types and constants for the LCD refresh scheduler: FSM states,
// frame-buffer geometry and the blank character loaded at reset.
package lcd_refresh_scheduler_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int LINE_WIDTH = 16;
    localparam int FB_DEPTH   = 1 << ADDR_W;

    localparam logic [DATA_W-1:0] BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_PRINT,
        ST_HOLDOFF
    } state_e;

endpackage

// File: rtl/lcd_refresh_scheduler_rr_arb2.sv
// Two-port round-robin arbiter: grants are combinational from the valids and
// the pointer; the pointer flips to the other port after every grant.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic a_vld,
    input  logic b_vld,
    output logic a_gnt,
    output logic b_gnt
);

    // ptr_q = 0 gives port A priority on a collision, 1 gives port B.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        a_gnt = a_vld & (~b_vld | ~ptr_q);
        b_gnt = b_vld & (~a_vld |  ptr_q);
        ptr_d = ptr_q;
        if (a_gnt) begin
            ptr_d = 1'b1;
        end else if (b_gnt) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// 64x8 frame buffer with two arbitrated write clients; retriggers the LCD driver
// whenever the buffer is dirty, with an ack timeout and an enforced idle gap.
module lcd_refresh_scheduler
    import lcd_refresh_scheduler_pkg::*;
#(
    parameter int MIN_GAP     = 2500,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              lcd_trg,
    input  logic              lcd_busy,
    input  logic [ADDR_W-1:0] lcd_addr,
    output logic [DATA_W-1:0] lcd_data,
    output logic              dirty,
    output logic              ack_err
);

    localparam int GAP_W = $clog2(MIN_GAP) + 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               dirty_q, dirty_d;
    logic               trg_q, trg_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  mem_q [FB_DEPTH];
    logic [DATA_W-1:0]  mem_d [FB_DEPTH];

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .a_vld (a_valid),
        .b_vld (b_valid),
        .a_gnt (a_ready),
        .b_gnt (b_ready)
    );

    assign wr_en   = a_ready | b_ready;
    assign wr_addr = a_ready ? a_addr : b_addr;
    assign wr_data = a_ready ? a_data : b_data;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        dirty_d = dirty_q;
        trg_d   = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                // A busy driver in IDLE is still initialising: hold off.
                if (dirty_q && !lcd_busy) begin
                    trg_d   = 1'b1;
                    dirty_d = 1'b0;
                    tmo_d   = TMO_W'(ACK_TIMEOUT - 1);
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (lcd_busy) begin
                    state_d = ST_PRINT;
                end else if (tmo_q == '0) begin
                    err_d   = 1'b1;
                    dirty_d = 1'b1;
                    gap_d   = GAP_W'(MIN_GAP - 1);
                    state_d = ST_HOLDOFF;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            ST_PRINT: begin
                if (!lcd_busy) begin
                    gap_d   = GAP_W'(MIN_GAP - 1);
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A write landing on the trigger edge must survive the clear.
        if (wr_en) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            tmo_q   <= '0;
            dirty_q <= 1'b1;
            trg_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < FB_DEPTH; i++) begin
                mem_q[i] <= BLANK_CHAR;
            end
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            dirty_q <= dirty_d;
            trg_q   <= trg_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign lcd_trg  = trg_q;
    assign dirty    = dirty_q;
    assign ack_err  = err_q;
    assign lcd_data = mem_q[lcd_addr];

endmodule
